// File: rtl/mult_share_arbiter.sv
// Round-robin share of one iterative signed multiplier; done pulses MULT_CYCLES+1 edges after accept.
// Backpressure: requests are only evaluated in IDLE and simply wait (req held) while busy.
module mult_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH1      = 8,
  parameter int WIDTH2      = 8,
  parameter int MULT_CYCLES = 10,
  parameter int GAP_CYCLES  = 1,
  parameter int ID_W        = 2
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*WIDTH1-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH2-1:0]   req_b,
  output logic [NUM_REQ-1:0]          gnt,
  output logic                        done,
  output logic [WIDTH1+WIDTH2-1:0]    result,
  output logic [ID_W-1:0]             result_id,
  output logic                        busy,
  output logic                        mult_en,
  output logic [WIDTH1-1:0]           mult_a,
  output logic [WIDTH2-1:0]           mult_b,
  output logic                        mult_cin,
  input  logic [WIDTH1+WIDTH2-1:0]    mult_sum
);

  localparam int CMAX  = (MULT_CYCLES > GAP_CYCLES) ? MULT_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, RUN, CAPTURE, GAP} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ID_W-1:0]            ptr_q, ptr_d;
  logic [ID_W-1:0]            win_q, win_d;
  logic [NUM_REQ-1:0]         gnt_q, gnt_d;
  logic                       done_q, done_d;
  logic [WIDTH1+WIDTH2-1:0]   result_q, result_d;
  logic [ID_W-1:0]            result_id_q, result_id_d;
  logic [WIDTH1-1:0]          mult_a_q, mult_a_d;
  logic [WIDTH2-1:0]          mult_b_q, mult_b_d;

  logic [2*NUM_REQ-1:0]       req_dbl;
  logic [NUM_REQ-1:0]         req_rot;
  logic                       found;
  logic [ID_W-1:0]            pick;
  int                         w;

  // Rotate so bit 0 is the pointer position; the lowest set bit is the circular winner.
  assign req_dbl = {req, req} >> ptr_q;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    found = 1'b0;
    pick  = '0;
    w     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        w = int'(ptr_q) + k;
        if (w >= NUM_REQ) w = w - NUM_REQ;
        pick = ID_W'(w);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_id_q <= '0;
      mult_a_q    <= '0;
      mult_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
      mult_a_q    <= mult_a_d;
      mult_b_q    <= mult_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = RUN;
          cnt_d   = RUN_LOAD;
        end
      end
      RUN: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      CAPTURE: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_id_d = result_id_q;
    mult_a_d    = mult_a_q;
    mult_b_d    = mult_b_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d    = pick;
          gnt_d    = NUM_REQ'(1) << pick;
          mult_a_d = WIDTH1'(req_a >> (int'(pick) * WIDTH1));
          mult_b_d = WIDTH2'(req_b >> (int'(pick) * WIDTH2));
        end
      end
      CAPTURE: begin
        result_d    = mult_sum;
        result_id_d = win_q;
        done_d      = 1'b1;
        gnt_d       = '0;
        if (win_q == ID_W'(NUM_REQ - 1)) ptr_d = '0;
        else                             ptr_d = win_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Enable and busy decode straight from state so an async reset drops them at once.
  always_comb begin
    busy      = (state_q != IDLE);
    mult_en   = (state_q == RUN);
    mult_cin  = 1'b0;
    gnt       = gnt_q;
    done      = done_q;
    result    = result_q;
    result_id = result_id_q;
    mult_a    = mult_a_q;
    mult_b    = mult_b_q;
  end

endmodule
